// File: rtl/div_unit_if.sv
// Handshake bundle for the iterative divider: request operands on one side,
// quotient/remainder result on the other.
interface div_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             is_word;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output in_valid, a, b, is_signed, is_word, out_ready,
        input  in_ready, out_valid, quot, rem
    );

    modport slave (
        input  in_valid, a, b, is_signed, is_word, out_ready,
        output in_ready, out_valid, quot, rem
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (signed/unsigned, 32-bit word mode) with
// RISC-V M-extension divide-by-zero and overflow results.
module div_unit #(
    parameter int WIDTH = 64,
    parameter int STEPS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam int CNT_W = $clog2(WIDTH / STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WIDTH / STEPS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(32 / STEPS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_word;

    logic [WIDTH-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min;
    logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_last;
    logic [WIDTH-1:0] w_prem_nx, w_dq_nx;
    logic [WIDTH-1:0] w_q_mag, w_r_mag, w_q_fix, w_r_fix;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
        return WIDTH'($signed(v));
    endfunction

    function automatic logic [WIDTH-1:0] zext32(input logic [31:0] v);
        return WIDTH'(v);
    endfunction

    // One restoring step: the borrow of the trial subtraction decides the quotient bit.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] prem,
                                                    input logic [WIDTH-1:0] dq,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        logic           qb;
        sh   = {prem, dq[WIDTH-1]};
        diff = sh - {1'b0, dvs};
        qb   = ~diff[WIDTH];
        return {(qb ? diff[WIDTH-1:0] : sh[WIDTH-1:0]), dq[WIDTH-2:0], qb};
    endfunction

    assign w_a_ext = bus.is_word ? (bus.is_signed ? sext32(bus.a[31:0]) : zext32(bus.a[31:0])) : bus.a;
    assign w_b_ext = bus.is_word ? (bus.is_signed ? sext32(bus.b[31:0]) : zext32(bus.b[31:0])) : bus.b;
    assign w_a_neg = bus.is_signed & w_a_ext[WIDTH-1];
    assign w_b_neg = bus.is_signed & w_b_ext[WIDTH-1];
    assign w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_min   = bus.is_word ? sext32(32'h8000_0000) : {1'b1, {(WIDTH-1){1'b0}}};
    assign w_div0  = (w_b_ext == '0);
    assign w_ovf   = bus.is_signed && (w_a_ext == w_min) && (&w_b_ext);
    assign w_last  = (r_cnt == (r_word ? LAST_WORD : LAST_FULL));

    always_comb begin
        w_prem_nx = r_prem;
        w_dq_nx   = r_dq;
        for (int i = 0; i < STEPS; i++) begin
            {w_prem_nx, w_dq_nx} = div_step(w_prem_nx, w_dq_nx, r_dvs);
        end
    end

    assign w_q_mag = r_neg_q ? -r_dq : r_dq;
    assign w_r_mag = r_neg_r ? -r_prem : r_prem;
    assign w_q_fix = r_word ? sext32(w_q_mag[31:0]) : w_q_mag;
    assign w_r_fix = r_word ? sext32(w_r_mag[31:0]) : w_r_mag;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) w_state_nxt = (w_div0 || w_ovf) ? S_DONE : S_CALC;
                S_CALC: if (w_last) w_state_nxt = S_FIX;
                S_FIX:  w_state_nxt = S_DONE;
                S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Word-mode dividends are left-aligned so 32 MSB-first steps consume exactly their bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_dq    <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_word  <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_cnt   <= '0;
                        r_prem  <= '0;
                        r_dvs   <= w_b_abs;
                        r_dq    <= bus.is_word ? (w_a_abs << (WIDTH - 32)) : w_a_abs;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_word  <= bus.is_word;
                        if (w_div0) begin
                            r_quot <= '1;
                            r_rem  <= w_a_ext;
                        end else if (w_ovf) begin
                            r_quot <= w_a_ext;
                            r_rem  <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_prem <= w_prem_nx;
                    r_dq   <= w_dq_nx;
                end
                S_FIX: begin
                    r_cnt  <= '0;
                    r_quot <= w_q_fix;
                    r_rem  <= w_r_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.quot      = r_quot;
    assign bus.rem       = r_rem;
endmodule
